// File: rtl/bit_serial_alu_ctrl.sv
// Sequences a 1-bit ALU slice across a WIDTH-bit operand pair, LSB first,
// providing AND/OR/ADD/SUB/SLT with done/zero/carry/overflow flags.
module bit_serial_alu_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic             i_ainvert,
  input  logic             i_binvert,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_cout,
  output logic             o_overflow
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic             r_ainv;
  logic             r_binv;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_cout;
  logic             r_overflow;

  logic             w_slt;
  logic             w_x;
  logic             w_y;
  logic             w_sum;
  logic             w_carry_out;
  logic             w_bit;
  logic             w_ovf;
  logic             w_lt;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] w_final;

  // One bit step of the slice; SLT always evaluates a - b
  always_comb begin
    w_slt       = (r_op == OP_SLT);
    w_x         = w_slt ? r_a[0] : (r_a[0] ^ r_ainv);
    w_y         = w_slt ? ~r_b[0] : (r_b[0] ^ r_binv);
    w_sum       = w_x ^ w_y ^ r_carry;
    w_carry_out = (w_x & w_y) | (w_x & r_carry) | (w_y & r_carry);
    case (r_op)
      OP_AND:  w_bit = w_x & w_y;
      OP_OR:   w_bit = w_x | w_y;
      default: w_bit = w_sum;
    endcase
    w_shift_nxt = (r_shift >> 1) | (WIDTH'(w_bit) << (WIDTH - 1));
    // r_carry holds the carry into the MSB while the last bit is processed
    w_ovf       = r_carry ^ w_carry_out;
    w_lt        = w_sum ^ w_ovf;
    w_final     = w_slt ? WIDTH'(w_lt) : w_shift_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= OP_AND;
      r_ainv     <= 1'b0;
      r_binv     <= 1'b0;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_op    <= i_op;
            r_ainv  <= i_ainvert;
            r_binv  <= i_binvert;
            r_carry <= (i_op == OP_SLT) ? 1'b1 : i_binvert;
            r_cnt   <= '0;
            r_shift <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_carry_out;
          r_shift <= w_shift_nxt;
          if (r_cnt == LAST_BIT) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_result   <= w_final;
            r_zero     <= (w_final == '0);
            r_cout     <= (r_op == OP_ADD) & w_carry_out;
            r_overflow <= (r_op == OP_ADD) & w_ovf;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_result   = r_result;
  assign o_zero     = r_zero;
  assign o_cout     = r_cout;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Directed and random checks of bit_serial_alu_ctrl against an arithmetic
// reference model.
module tb_bit_serial_alu_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned W1 = W + 1;

  logic         clk = 1'b0;
  logic         i_reset = 1'b1;
  logic         i_start = 1'b0;
  logic [1:0]   i_op = 2'b00;
  logic         i_ainvert = 1'b0;
  logic         i_binvert = 1'b0;
  logic [W-1:0] i_a = '0;
  logic [W-1:0] i_b = '0;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_result;
  logic         o_zero;
  logic         o_cout;
  logic         o_overflow;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] last_res  = '0;
  logic         last_zero = 1'b0;
  logic         last_cout = 1'b0;
  logic         last_ovf  = 1'b0;

  bit_serial_alu_ctrl #(.WIDTH(W)) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_op       (i_op),
    .i_ainvert  (i_ainvert),
    .i_binvert  (i_binvert),
    .i_a        (i_a),
    .i_b        (i_b),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_result   (o_result),
    .o_zero     (o_zero),
    .o_cout     (o_cout),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: whole-word arithmetic on the (optionally inverted) operands
  function automatic void model(input logic [1:0] op, input logic ai, input logic bi,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic z,
                                output logic c, output logic v);
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    logic [W:0]   s;
    ea = ai ? ~a : a;
    eb = bi ? ~b : b;
    c  = 1'b0;
    v  = 1'b0;
    case (op)
      2'b00: r = ea & eb;
      2'b01: r = ea | eb;
      2'b10: begin
        s = {1'b0, ea} + {1'b0, eb} + W1'(bi);
        r = s[W-1:0];
        c = s[W];
        v = (ea[W-1] == eb[W-1]) && (r[W-1] != ea[W-1]);
      end
      default: r = ($signed(a) < $signed(b)) ? W'(1) : '0;
    endcase
    z = (r == '0);
  endfunction

  // Starts one op from IDLE and checks latency, outputs and the held result.
  // poke drives extra starts in RUN cycles 3 and 8 and during DONE.
  task automatic run_op(input string tag, input logic [1:0] op, input logic ai,
                        input logic bi, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit poke);
    logic [W-1:0] er;
    logic         ez, ec, ev;
    int           lat;
    bit           got;
    model(op, ai, bi, a, b, er, ez, ec, ev);
    i_op = op; i_ainvert = ai; i_binvert = bi; i_a = a; i_b = b;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk({tag, ".busy_run"}, 32'(o_busy), 32'd1);
    chk({tag, ".held_result"}, 32'(o_result), 32'(last_res));
    chk({tag, ".held_flags"}, 32'({o_zero, o_cout, o_overflow}),
        32'({last_zero, last_cout, last_ovf}));
    i_a = W'($urandom);
    i_b = W'($urandom);
    i_op = 2'($urandom);
    i_ainvert = ~ai;
    i_binvert = ~bi;
    lat = 0;
    got = 1'b0;
    for (int k = 1; k <= 3 * W && !got; k++) begin
      if (poke && (k == 3 || k == W)) i_start = 1'b1;
      step();
      i_start = 1'b0;
      if (o_done) begin
        got = 1'b1;
        lat = k;
      end
    end
    chk({tag, ".latency"}, 32'(lat), 32'(W));
    chk({tag, ".result"}, 32'(o_result), 32'(er));
    chk({tag, ".zero"}, 32'(o_zero), 32'(ez));
    chk({tag, ".cout"}, 32'(o_cout), 32'(ec));
    chk({tag, ".overflow"}, 32'(o_overflow), 32'(ev));
    chk({tag, ".busy_done"}, 32'(o_busy), 32'd0);
    if (poke) i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk({tag, ".done_drop"}, 32'(o_done), 32'd0);
    chk({tag, ".busy_idle"}, 32'(o_busy), 32'd0);
    if (poke) begin
      step();
      chk({tag, ".no_second_op"}, 32'({o_busy, o_done}), 32'd0);
      chk({tag, ".result_kept"}, 32'(o_result), 32'(er));
    end
    last_res = er; last_zero = ez; last_cout = ec; last_ovf = ev;
  endtask

  initial begin
    int dones;
    step();
    step();
    chk("reset.busy", 32'(o_busy), 32'd0);
    chk("reset.done", 32'(o_done), 32'd0);
    chk("reset.result", 32'(o_result), 32'd0);
    chk("reset.flags", 32'({o_zero, o_cout, o_overflow}), 32'd0);
    i_reset = 1'b0;
    step();
    chk("idle.busy", 32'(o_busy), 32'd0);

    run_op("add_ovf", 2'b10, 1'b0, 1'b0, 8'h7F, 8'h01, 1'b0);
    run_op("sub_eq", 2'b10, 1'b0, 1'b1, 8'h05, 8'h05, 1'b0);
    run_op("slt_true", 2'b11, 1'b0, 1'b0, 8'hFE, 8'h03, 1'b0);
    run_op("slt_false", 2'b11, 1'b0, 1'b0, 8'h03, 8'hFE, 1'b0);
    run_op("nor", 2'b00, 1'b1, 1'b1, 8'hF0, 8'h0C, 1'b0);
    run_op("or", 2'b01, 1'b0, 1'b0, 8'hA0, 8'h05, 1'b0);
    run_op("slt_inv_ignored", 2'b11, 1'b1, 1'b1, 8'h80, 8'h7F, 1'b0);
    run_op("poke", 2'b10, 1'b0, 1'b0, 8'h12, 8'h34, 1'b1);
    run_op("b2b", 2'b10, 1'b0, 1'b1, 8'h80, 8'h01, 1'b0);

    // Abort an ADD mid-run
    i_op = 2'b10; i_ainvert = 1'b0; i_binvert = 1'b0; i_a = 8'h55; i_b = 8'h2B;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    chk("abort.busy", 32'(o_busy), 32'd0);
    chk("abort.done", 32'(o_done), 32'd0);
    chk("abort.result", 32'(o_result), 32'd0);
    chk("abort.flags", 32'({o_zero, o_cout, o_overflow}), 32'd0);
    dones = 0;
    for (int k = 0; k < 2 * W; k++) begin
      step();
      if (o_done || o_busy) dones++;
    end
    chk("abort.no_activity", 32'(dones), 32'd0);
    last_res = '0; last_zero = 1'b0; last_cout = 1'b0; last_ovf = 1'b0;
    run_op("after_abort", 2'b10, 1'b0, 1'b0, 8'h55, 8'h2B, 1'b0);

    for (int n = 0; n < 24; n++) begin
      run_op($sformatf("rand%0d", n), 2'($urandom_range(0, 3)), 1'($urandom),
             1'($urandom), W'($urandom), W'($urandom), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
